priority_scan_encoder: RTL and testbench
========================================

PRIORITY_SCAN_ENCODER -- requirements
Module: priority_scan_encoder

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, meaning the input vector width (legal range 2..256).
REQ-002 The block SHALL have the parameter CODE_W, default 3, meaning the code width; it SHALL equal ceil(log2(WIDTH)).
REQ-003 The block SHALL have the parameter MSB_FIRST, default 0, meaning 0 = scan from bit 0 upward and 1 = scan from bit WIDTH-1 downward.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have the port in_valid, input, 1 bit: an input vector is offered.
REQ-007 The block SHALL have the port in_ready, output, 1 bit: the block can accept a vector.
REQ-008 The block SHALL have the port in_data, input, WIDTH bits: the multi-hot vector to encode.
REQ-009 The block SHALL have the port out_valid, output, 1 bit: an output beat is presented.
REQ-010 The block SHALL have the port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-011 The block SHALL have the port out_code, output, CODE_W bits: the index of the current set bit.
REQ-012 The block SHALL have the port out_last, output, 1 bit: the current beat is the final beat of the vector.
REQ-013 The block SHALL have the port out_zero, output, 1 bit: the accepted vector had no set bits.

Function
REQ-014 The FSM SHALL have the states IDLE and SCAN, held in a registered state variable.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in SCAN, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-016 An input handshake (in_valid and in_ready high at a rising edge) SHALL load in_data into an internal pending register and move the FSM to SCAN.
REQ-017 When accepted in cycle N, the first output beat SHALL be valid in cycle N+1; there is no combinational path from in_data to out_code.
REQ-018 In SCAN with pending nonzero, out_code SHALL be the lowest set index of pending if MSB_FIRST=0, or the highest set index if MSB_FIRST=1.
REQ-019 out_last SHALL be 1 exactly when pending has one set bit.
REQ-020 An output handshake (out_valid and out_ready high) SHALL clear the reported bit in pending; if out_last=1, the FSM SHALL return to IDLE.
REQ-021 An accepted all-zero vector SHALL produce exactly one beat with out_code=0, out_zero=1, out_last=1; out_zero SHALL be 0 on every other beat.
REQ-022 While out_valid=1 and out_ready=0, out_code, out_last and out_zero SHALL hold stable.
REQ-023 A vector with K set bits SHALL produce exactly K beats (1 beat if K=0), with strictly increasing codes (MSB_FIRST=0) or strictly decreasing codes (MSB_FIRST=1).
REQ-024 Sustained throughput SHALL be K beats plus one IDLE accept cycle per vector; no back-to-back accept SHALL occur in the last-beat cycle.
REQ-025 in_data SHALL be ignored while in_ready=0; changes to in_data during SCAN SHALL NOT affect pending.
REQ-026 When WIDTH is not a power of two, out_code SHALL never exceed WIDTH-1.
REQ-027 When in IDLE, out_code, out_last and out_zero SHALL be 0.

Reset
REQ-028 Asserting rst SHALL immediately, without waiting for clk, force state=IDLE, pending=0, out_valid=0, in_ready=1, out_code=0, out_last=0 and out_zero=0.
REQ-029 rst asserted mid-SCAN SHALL discard the remaining beats; after rst deasserts, no beat of the aborted vector SHALL appear.
REQ-030 The first rising clk edge with rst low SHALL be able to accept a vector.

Verification
REQ-031 Test: WIDTH=8, MSB_FIRST=0, in_data=8'b1010_0110, out_ready=1 -> codes 1,2,5,7 on consecutive cycles, out_last only on 7, then in_ready=1.
REQ-032 Test: same vector with MSB_FIRST=1 -> codes 7,5,2,1, out_last on 1.
REQ-033 Test: in_data=8'h00 -> a single beat with out_code=0, out_zero=1, out_last=1.
REQ-034 Test: in_data=8'h80 with out_ready held low for 3 cycles -> out_code=7 with out_last=1 held stable for 4 cycles, consumed on the 4th.
REQ-035 Test: rst pulsed asynchronously after the 2nd beat of 8'hFF -> outputs reset at once with no clk edge; the next vector 8'h01 yields a single code 0.
REQ-036 Test: WIDTH=5, CODE_W=3, in_data=5'b1_0001 -> codes 0,4; random multi-hot vectors with random out_ready SHALL match a reference model for popcount, order and last.

Source files
------------

// File: rtl/priority_scan_encoder.sv
// Priority scan encoder: accepts a multi-hot vector, then emits one beat per
// set bit (lowest-first or highest-first), clearing each bit as it is consumed.
// An all-zero vector yields a single beat flagged with out_zero.
module priority_scan_encoder #(
  parameter int WIDTH     = 8,
  parameter int CODE_W    = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              out_zero
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WIDTH-1:0]  pending_q, pending_d;
  logic              zero_q, zero_d;

  logic [CODE_W-1:0] sel_code;
  logic [WIDTH-1:0]  sel_mask;
  logic              single_bit;

  // Pick the next bit to report; the last hit in the loop order wins, so the
  // loop runs opposite to the desired priority.
  always_comb begin
    sel_code = '0;
    sel_mask = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pending_q[i]) begin
          sel_code    = CODE_W'(i);
          sel_mask    = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          sel_code    = CODE_W'(i);
          sel_mask    = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end
  end

  // Outputs derive only from registered state, so nothing from in_data
  // reaches out_code combinationally and reset takes effect immediately.
  always_comb begin
    single_bit = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == SCAN);
    out_code   = out_valid ? sel_code : '0;
    out_last   = out_valid & (zero_q | single_bit);
    out_zero   = out_valid & zero_q;
  end

  // Next-state logic: load on accept, strip the reported bit on each consumed
  // beat, and return to IDLE after the final beat.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_data;
          zero_d    = (in_data == '0);
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_d = pending_q & ~sel_mask;
          if (out_last) begin
            state_d = IDLE;
            zero_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
        zero_d    = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset that discards any pending vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Scoreboard bench for priority_scan_encoder: three instances (LSB-first x8,
// MSB-first x8, LSB-first x5) share clock and reset; expected beats come from
// a bit-list model and a per-instance monitor compares every consumed beat.
module tb_priority_scan_encoder;

  typedef struct packed {
    logic [2:0] code;
    logic       last;
    logic       zero;
  } beat_t;

  logic       clk;
  logic       rst;
  logic       inValid  [3];
  logic       inReady  [3];
  logic [7:0] inData   [3];
  logic       outValid [3];
  logic       outReady [3];
  logic [2:0] outCode  [3];
  logic       outLast  [3];
  logic       outZero  [3];

  beat_t q0[$];
  beat_t q1[$];
  beat_t q2[$];

  int    readyMode [3];
  bit    holdValid [3];
  beat_t heldBeat  [3];
  int    popCount  [3];
  int    compared;
  int    mismatched;

  priority_scan_encoder #(.WIDTH(8), .CODE_W(3), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_data(inData[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_code(outCode[0]), .out_last(outLast[0]), .out_zero(outZero[0]));

  priority_scan_encoder #(.WIDTH(8), .CODE_W(3), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_data(inData[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_code(outCode[1]), .out_last(outLast[1]), .out_zero(outZero[1]));

  priority_scan_encoder #(.WIDTH(5), .CODE_W(3), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in_data(inData[2][4:0]), .out_valid(outValid[2]), .out_ready(outReady[2]),
    .out_code(outCode[2]), .out_last(outLast[2]), .out_zero(outZero[2]));

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int k, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s inst%0d actual=%0d expected=%0d at t=%0t", name, k, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name, input int k);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s inst%0d actual=timeout expected=event at t=%0t", name, k, $time);
  endtask

  function automatic int qSize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pushBeat(input int k, input beat_t b);
    case (k)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic popBeat(input int k, output beat_t b, output bit ok);
    ok = (qSize(k) != 0);
    b  = '0;
    if (ok) begin
      case (k)
        0:       b = q0.pop_front();
        1:       b = q1.pop_front();
        default: b = q2.pop_front();
      endcase
    end
  endtask

  // Reference model: list the set bit positions in scan order, one beat each.
  task automatic modelBeats(input int k, input logic [7:0] v);
    int    w;
    int    idx[$];
    beat_t b;
    w = (k == 2) ? 5 : 8;
    for (int i = 0; i < w; i++) begin
      if (v[i]) begin
        if (k == 1) idx.push_front(i);
        else        idx.push_back(i);
      end
    end
    if (idx.size() == 0) begin
      b.code = 3'd0;
      b.last = 1'b1;
      b.zero = 1'b1;
      pushBeat(k, b);
    end else begin
      for (int j = 0; j < idx.size(); j++) begin
        b.code = 3'(idx[j]);
        b.last = (j == idx.size() - 1);
        b.zero = 1'b0;
        pushBeat(k, b);
      end
    end
  endtask

  task automatic monitorInst(input int k);
    beat_t cur;
    beat_t exp;
    bit    ok;
    cur.code = outCode[k];
    cur.last = outLast[k];
    cur.zero = outZero[k];
    if (outValid[k]) begin
      checkOutput("inReadyInScan", k, int'(inReady[k]), 0);
      if (holdValid[k]) checkOutput("holdStable", k, int'(cur), int'(heldBeat[k]));
      if (outReady[k]) begin
        popBeat(k, exp, ok);
        if (!ok) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedBeat inst%0d actual=code%0d expected=none", k, cur.code);
        end else begin
          popCount[k]++;
          checkOutput("beatCode", k, int'(cur.code), int'(exp.code));
          checkOutput("beatLast", k, int'(cur.last), int'(exp.last));
          checkOutput("beatZero", k, int'(cur.zero), int'(exp.zero));
        end
        holdValid[k] = 1'b0;
      end else begin
        holdValid[k] = 1'b1;
        heldBeat[k]  = cur;
      end
    end else begin
      holdValid[k] = 1'b0;
      checkOutput("idleReady", k, int'(inReady[k]), 1);
      checkOutput("idleOutputs", k, int'(cur), 0);
    end
  endtask

  // Monitor: sample every instance mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) monitorInst(k);
    end
  end

  // Consumer: refresh out_ready just after each rising edge per instance mode.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (readyMode[k] == 0)      outReady[k] = 1'b1;
        else if (readyMode[k] == 1) outReady[k] = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic applyStimulus(input int k, input logic [7:0] v);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      #1;
      if (inReady[k]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      failNow("waitInReady", k);
    end else begin
      inValid[k] = 1'b1;
      inData[k]  = v;
      modelBeats(k, v);
      @(posedge clk);
      #1;
      checkOutput("acceptLatency", k, int'(outValid[k]), 1);
      inValid[k] = 1'b0;
      inData[k]  = 8'($urandom);
    end
  endtask

  task automatic waitIdle(input int k);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      #1;
      if (qSize(k) == 0 && inReady[k]) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) failNow("drain", k);
  endtask

  task automatic checkResetState(input string name);
    for (int k = 0; k < 3; k++) begin
      checkOutput({name, "Valid"}, k, int'(outValid[k]), 0);
      checkOutput({name, "Ready"}, k, int'(inReady[k]), 1);
      checkOutput({name, "Code"}, k, int'(outCode[k]), 0);
      checkOutput({name, "Last"}, k, int'(outLast[k]), 0);
      checkOutput({name, "Zero"}, k, int'(outZero[k]), 0);
    end
  endtask

  // Main sequence: directed cases, asynchronous abort, then random traffic.
  initial begin
    int         base;
    bit         hit;
    logic [7:0] v;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inValid[k]   = 1'b0;
      inData[k]    = 8'h00;
      outReady[k]  = 1'b1;
      readyMode[k] = 0;
      holdValid[k] = 1'b0;
      popCount[k]  = 0;
    end

    #12;
    checkResetState("reset");

    // Offer a vector before reset releases; the first edge must take it.
    #10;
    inValid[0] = 1'b1;
    inData[0]  = 8'h01;
    modelBeats(0, 8'h01);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("firstEdgeAccept", 0, int'(outValid[0]), 1);
    inValid[0] = 1'b0;
    waitIdle(0);

    applyStimulus(0, 8'b1010_0110);
    waitIdle(0);
    applyStimulus(1, 8'b1010_0110);
    waitIdle(1);
    applyStimulus(0, 8'h00);
    waitIdle(0);
    applyStimulus(2, 8'b0001_0001);
    waitIdle(2);

    // Backpressure: hold out_ready low for three cycles on a single-bit vector.
    readyMode[0] = 2;
    outReady[0]  = 1'b0;
    applyStimulus(0, 8'h80);
    repeat (3) @(posedge clk);
    #1;
    outReady[0] = 1'b1;
    waitIdle(0);
    readyMode[0] = 0;

    // Abort a scan of 8'hFF after its second beat with an off-edge reset.
    base = popCount[0];
    applyStimulus(0, 8'hFF);
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      if (popCount[0] >= base + 2) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) failNow("abortWait", 0);
    #2;
    checkOutput("preAbortValid", 0, int'(outValid[0]), 1);
    rst = 1'b1;
    #1;
    checkResetState("asyncReset");
    q0.delete();
    q1.delete();
    q2.delete();
    for (int k = 0; k < 3; k++) holdValid[k] = 1'b0;
    #1;
    rst = 1'b0;
    applyStimulus(0, 8'h01);
    waitIdle(0);

    // Random vectors with random consumer stalls on each instance.
    for (int k = 0; k < 3; k++) begin
      readyMode[k] = 1;
      for (int n = 0; n < 40; n++) begin
        v = 8'($urandom);
        if ($urandom_range(0, 7) == 0) v = 8'h00;
        if (k == 2) v = v & 8'h1F;
        applyStimulus(k, v);
      end
      waitIdle(k);
      readyMode[k] = 0;
    end

    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) checkOutput("queueEmpty", k, qSize(k), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
